// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor.
//   The operands are split into SEG-bit segments, one pipeline stage per segment.
//   Each stage resolves its segment with 4-bit CLA groups. The groups use
//   lookahead between them. Unused operand bits ride along to the next stage.
//   Throughput is one operation per cycle. Handshake is valid/ready.
//   Empty stages accept data even while downstream is stalled, so bubbles collapse.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands present
//   in_ready   block accepts this cycle (forced low while rst is high)
//   a, b       WIDTH-bit operands
//   cin        carry-in; used only when sub=0
//   sub        1: a - b ; 0: a + b + cin
//   out_valid  result present
//   out_ready  consumer takes the result
//   sum        WIDTH-bit result
//   cout       carry out of the MSB (for sub: 1 = no borrow)
//   ovf        two's-complement overflow
//   zero       sum == 0
`timescale 1ns/1ps
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / SEG;
  localparam int NG = SEG / 4;

  if ((SEG < 4) || (SEG % 4 != 0) || (WIDTH < SEG) || (WIDTH % SEG != 0)) begin : g_param_err
    $error("cla_pipe_addsub: SEG must be a multiple of 4 and WIDTH a multiple of SEG");
  end

  // One SEG-bit segment. The function returns {carry_out, sum[SEG-1:0]}.
  // Every carry is written in expanded sum-of-products form, both for the
  // group carries and for the bit carries inside each group. No carry
  // ripples through another carry.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [SEG-1:0] p, g;
    logic [SEG:0]   c;
    logic [NG-1:0]  gp, gg;
    logic [NG:0]    gc;
    logic           acc, pr;
    p = x ^ y;
    g = x & y;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    gc[0] = ci;
    for (int j = 1; j <= NG; j++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int i = j - 1; i >= 0; i--) begin
        acc = acc | (pr & gg[i]);
        pr  = pr & gp[i];
      end
      gc[j] = acc | (pr & ci);
    end
    for (int j = 0; j < NG; j++) begin
      c[4*j] = gc[j];
      for (int k = 1; k < 4; k++) begin
        acc = 1'b0;
        pr  = 1'b1;
        for (int i = k - 1; i >= 0; i--) begin
          acc = acc | (pr & g[4*j+i]);
          pr  = pr & p[4*j+i];
        end
        c[4*j+k] = acc | (pr & gc[j]);
      end
    end
    c[SEG] = gc[NG];
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  logic [N:0]   w_rdy;
  logic [N-1:0] w_vld;

  // Ready chain: a stage can take new data when it is empty or when it is
  // handing its own data onward in the same cycle.
  assign w_rdy[N] = out_ready;
  for (genvar k = 0; k < N; k++) begin : g_rdy
    assign w_rdy[k] = ~w_vld[k] | w_rdy[k+1];
  end
  assign in_ready = w_rdy[0] & ~rst;

  for (genvar k = 0; k < N; k++) begin : g_st
    localparam int LO   = k * SEG;
    localparam int HI_W = WIDTH - LO;

    logic [HI_W-1:0]     w_a, w_b;
    logic                w_ci, w_vin;
    logic [SEG:0]        w_seg;
    logic [LO+SEG-1:0]   w_res;
    logic                r_vld, r_c;
    logic [LO+SEG-1:0]   r_res;

    if (k == 0) begin : g_in
      // b is inverted here when sub=1, and the carry-in becomes 1.
      assign w_a   = a;
      assign w_b   = b ^ {WIDTH{sub}};
      assign w_ci  = sub | cin;
      assign w_vin = in_valid;
      assign w_res = w_seg[SEG-1:0];
    end else begin : g_link
      assign w_a   = g_st[k-1].g_ops.r_a;
      assign w_b   = g_st[k-1].g_ops.r_b;
      assign w_ci  = g_st[k-1].r_c;
      assign w_vin = g_st[k-1].r_vld;
      assign w_res = {w_seg[SEG-1:0], g_st[k-1].r_res};
    end

    assign w_seg    = cla_seg(w_a[SEG-1:0], w_b[SEG-1:0], w_ci);
    assign w_vld[k] = r_vld;

    // ---- stage k register boundary ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_res <= '0;
      end else if (w_rdy[k]) begin
        r_vld <= w_vin;
        if (w_vin) begin
          r_c   <= w_seg[SEG];
          r_res <= w_res;
        end
      end
    end

    if (k < N - 1) begin : g_ops
      logic [HI_W-SEG-1:0] r_a, r_b;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_rdy[k] && w_vin) begin
          r_a <= w_a[HI_W-1:SEG];
          r_b <= w_b[HI_W-1:SEG];
        end
      end
    end else begin : g_last
      logic r_ovf, r_zero;
      // The carry into the MSB is recovered from the sum bit:
      // sum = x ^ y ^ c, so c = sum ^ x ^ y.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_rdy[k] && w_vin) begin
          r_ovf  <= w_seg[SEG-1] ^ w_a[SEG-1] ^ w_b[SEG-1] ^ w_seg[SEG];
          r_zero <= ~|w_res;
        end
      end
    end
  end

  assign out_valid = g_st[N-1].r_vld;
  assign sum       = g_st[N-1].r_res;
  assign cout      = g_st[N-1].r_c;
  assign ovf       = g_st[N-1].g_last.r_ovf;
  assign zero      = g_st[N-1].g_last.r_zero;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
`timescale 1ns/1ps
module tb_cla_pipe_addsub;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, sub, cout, ovf, zero;

  cla_pipe_addsub #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  res_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  bit   last_acc = 1'b0;

  // Reference: plain wide arithmetic plus sign rules for overflow.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input logic c);
    res_t        r;
    logic [32:0] t;
    if (s) t = {1'b0, x} - {1'b0, y} + 33'h1_0000_0000;
    else   t = {1'b0, x} + {1'b0, y} + {32'd0, c};
    r.s  = t[31:0];
    r.co = t[32];
    if (s) r.ov = (x[31] != y[31]) && (r.s[31] != x[31]);
    else   r.ov = (x[31] == y[31]) && (r.s[31] != x[31]);
    r.z  = (r.s == 32'd0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: accepts and output transfers are observed at the negedge.
  // Both are decided for the coming posedge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      last_acc = 1'b0;
    end else begin
      last_acc = in_valid && in_ready;
      if (last_acc) sb.push_back(model(a, b, sub, cin));
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got sum=%h, expected no output", sum);
        end else begin
          res_t e;
          e = sb.pop_front();
          chk("result", 64'({sum, cout, ovf, zero}), 64'(e));
        end
      end
    end
  end

  task automatic wait_accept(input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s_accept_timeout: got in_ready=0, expected 1 within 200 cycles", nm);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sb.size() != 0 || out_valid) && k < 300) begin
      @(posedge clk); #1; k++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // Single op on an empty pipe with out_ready=1. Checks latency and result.
  task automatic lat_check(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                           input logic ts, input logic tc, input logic [31:0] xs,
                           input logic [2:0] xf);
    a = ta; b = tb_; sub = ts; cin = tc; in_valid = 1'b1;
    wait_accept(nm);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk({nm, "_vld"}, 64'(out_valid), 64'(c == 3));
      if (c < 3) begin @(posedge clk); #1; end
    end
    chk({nm, "_sum"}, 64'(sum), 64'(xs));
    chk({nm, "_flags"}, 64'({cout, ovf, zero}), 64'(xf));
    @(posedge clk); #1;
  endtask

  logic [31:0] ta[6], tbv[6];
  logic        ts[6], tc[6];

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    res_t first;
    int   idx, n0, k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_flags", 64'({cout, ovf, zero}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    lat_check("add_1_2",   32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 3'b000);
    lat_check("carry_all", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 3'b101);
    lat_check("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 3'b010);
    lat_check("sub_5_7",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 3'b000);
    lat_check("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 3'b110);
    lat_check("wrap",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 3'b101);
    wait_drain();

    // Backpressure: 6 back-to-back ops into a stalled pipe.
    for (int i = 0; i < 6; i++) begin
      ta[i] = $urandom; tbv[i] = $urandom; ts[i] = 1'($urandom); tc[i] = 1'($urandom);
    end
    first = model(ta[0], tbv[0], ts[0], tc[0]);
    out_ready = 1'b0; idx = 0;
    a = ta[0]; b = tbv[0]; sub = ts[0]; cin = tc[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1; idx++;
        if (idx < 6) begin a = ta[idx]; b = tbv[idx]; sub = ts[idx]; cin = tc[idx]; end
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("bp_accepted", 64'(idx), 64'd4);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_sum", 64'(sum), 64'(first.s));
    @(posedge clk); #1;
    chk("bp_hold_sum2", 64'(sum), 64'(first.s));
    n0 = n_out;
    out_ready = 1'b1;
    k = 0;
    while (idx < 6 && k < 50) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1; idx++;
        if (idx < 6) begin a = ta[idx]; b = tbv[idx]; sub = ts[idx]; cin = tc[idx]; end
      end else begin
        @(posedge clk); #1;
      end
      k++;
    end
    in_valid = 1'b0;
    wait_drain();
    chk("bp_out_count", 64'(n_out - n0), 64'd6);

    // Bubble collapse.
    out_ready = 1'b0;
    a = 32'd10; b = 32'd20; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    wait_accept("bub1");
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 32'd100; b = 32'd1; sub = 1'b1; in_valid = 1'b1;
    wait_accept("bub2");
    in_valid = 1'b0;
    chk("bub_out_valid", 64'(out_valid), 64'd1);
    chk("bub_in_ready", 64'(in_ready), 64'd1);
    chk("bub_sum", 64'(sum), 64'd30);
    out_ready = 1'b1;
    wait_drain();

    // Reset with 3 ops in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      wait_accept("rs_op");
    end
    in_valid = 1'b0;
    @(posedge clk); #3;
    chk("rs_pre_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_sum", 64'(sum), 64'd0);
    chk("rs_flags", 64'({cout, ovf, zero}), 64'd0);
    chk("rs_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("rs_no_stale", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    lat_check("rs_new", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 3'b000);
    wait_drain();

    // Randomized stream with random backpressure.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      if (!in_valid || last_acc) begin
        in_valid = ($urandom % 4) != 0;
        a = pick(); b = pick(); sub = 1'($urandom); cin = 1'($urandom);
      end
      out_ready = ($urandom % 4) != 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule
